btn_pulse_gen: RTL and testbench

//   Conditions a raw, active-low, asynchronous push-button into the one-cycle

---
 rtl/btn_pulse_gen.sv | 165 ++++++++++++++++
 tb/tb_btn_pulse_gen.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/btn_pulse_gen.sv
// Front-panel button conditioner: synchronise, debounce, edge-detect and
// auto-repeat a raw active-low button into a one-cycle active-low strobe.
module btn_pulse_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter bit          REPEAT_EN       = 1'b1,
  parameter int unsigned REPEAT_DELAY    = 500,
  parameter int unsigned REPEAT_PERIOD   = 100,
  parameter int unsigned CNT_W           = 20
) (
  input  logic clk_ctrl,
  input  logic reset_n,
  input  logic btn_n,
  output logic pulse_n,
  output logic pressed,
  output logic held
);

  localparam logic [63:0] CNT_LIMIT = 64'd1 << CNT_W;
  localparam bit PARAMS_OK = (DEBOUNCE_CYCLES >= 1) && (REPEAT_DELAY >= 2) &&
                             (REPEAT_PERIOD >= 2) && (CNT_W >= 1) && (CNT_W <= 32) &&
                             (64'(DEBOUNCE_CYCLES) < CNT_LIMIT) &&
                             (64'(REPEAT_DELAY) < CNT_LIMIT) &&
                             (64'(REPEAT_PERIOD) < CNT_LIMIT);

  generate
    if (!PARAMS_OK) begin : g_param_err
      $error("btn_pulse_gen: parameters out of range for CNT_W");
    end
  endgenerate

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESSED = 2'd1,
    S_REPEAT  = 2'd2
  } state_t;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic [CNT_W-1:0] r_db_cnt;
  logic [CNT_W-1:0] r_rep_cnt;
  state_t           r_state;

  state_t           w_state_nxt;
  logic             w_pulse_n_nxt;
  logic             w_held_nxt;
  logic [CNT_W-1:0] w_rep_cnt_nxt;

  // Two-flop synchroniser; idle level is released (1).
  always_ff @(posedge clk_ctrl or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= btn_n;
      r_sync2 <= r_sync1;
    end
  end

  // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk_ctrl or negedge reset_n) begin
    if (!reset_n) begin
      r_stable <= 1'b1;
      r_db_cnt <= CNT_ZERO;
    end else if (r_sync2 != r_stable) begin
      if (r_db_cnt == DB_LAST) begin
        r_stable <= r_sync2;
        r_db_cnt <= CNT_ZERO;
      end else begin
        r_db_cnt <= r_db_cnt + CNT_ONE;
      end
    end else begin
      r_db_cnt <= CNT_ZERO;
    end
  end

  always_ff @(posedge clk_ctrl or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (!r_stable) w_state_nxt = S_PRESSED;
      end
      S_PRESSED: begin
        if (r_stable) begin
          w_state_nxt = S_IDLE;
        end else if (REPEAT_EN && (r_rep_cnt == RD_LAST)) begin
          w_state_nxt = S_REPEAT;
        end
      end
      S_REPEAT: begin
        if (r_stable) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A release always beats a strobe that would fall due on the same cycle.
  always_comb begin
    w_pulse_n_nxt = 1'b1;
    w_held_nxt    = 1'b0;
    w_rep_cnt_nxt = r_rep_cnt;
    case (r_state)
      S_IDLE: begin
        if (!r_stable) begin
          w_pulse_n_nxt = 1'b0;
          w_rep_cnt_nxt = CNT_ZERO;
        end
      end
      S_PRESSED: begin
        if (!r_stable && REPEAT_EN) begin
          if (r_rep_cnt == RD_LAST) begin
            w_pulse_n_nxt = 1'b0;
            w_held_nxt    = 1'b1;
            w_rep_cnt_nxt = CNT_ZERO;
          end else begin
            w_rep_cnt_nxt = r_rep_cnt + CNT_ONE;
          end
        end
      end
      S_REPEAT: begin
        if (!r_stable) begin
          w_held_nxt = 1'b1;
          if (r_rep_cnt == RP_LAST) begin
            w_pulse_n_nxt = 1'b0;
            w_rep_cnt_nxt = CNT_ZERO;
          end else begin
            w_rep_cnt_nxt = r_rep_cnt + CNT_ONE;
          end
        end
      end
      default: begin
        w_pulse_n_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_ctrl or negedge reset_n) begin
    if (!reset_n) begin
      pulse_n   <= 1'b1;
      pressed   <= 1'b0;
      held      <= 1'b0;
      r_rep_cnt <= CNT_ZERO;
    end else begin
      pulse_n   <= w_pulse_n_nxt;
      pressed   <= ~r_stable;
      held      <= w_held_nxt;
      r_rep_cnt <= w_rep_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_btn_pulse_gen.sv
// Bench for btn_pulse_gen: two instances (auto-repeat on/off) sharing one
// button, checked every cycle against a time-since-press reference model.
module tb_btn_pulse_gen;

  localparam int unsigned DB = 4;
  localparam int unsigned RD = 10;
  localparam int unsigned RP = 3;

  logic clk_ctrl = 1'b0;
  logic reset_n;
  logic btn_n;
  logic a_pulse_n, a_pressed, a_held;
  logic b_pulse_n, b_pressed, b_held;

  int n_checks = 0;
  int n_pass   = 0;
  int stepno   = 0;

  // Reference model state
  logic m_stable;
  logic m_pressed;
  logic m_pulse_n [2];
  logic m_held    [2];
  bit   m_act     [2];
  int   m_t       [2];
  logic dq[$];
  logic hist[$];

  int   a_strobes[$];
  int   b_strobes[$];
  int   t0;
  bit   a_held_seen;
  bit   a_pressed_seen;

  always #5 clk_ctrl = ~clk_ctrl;

  btn_pulse_gen #(
    .DEBOUNCE_CYCLES(DB), .REPEAT_EN(1'b1), .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP), .CNT_W(8)
  ) u_rep (
    .clk_ctrl(clk_ctrl), .reset_n(reset_n), .btn_n(btn_n),
    .pulse_n(a_pulse_n), .pressed(a_pressed), .held(a_held)
  );

  btn_pulse_gen #(
    .DEBOUNCE_CYCLES(DB), .REPEAT_EN(1'b0), .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP), .CNT_W(8)
  ) u_norep (
    .clk_ctrl(clk_ctrl), .reset_n(reset_n), .btn_n(btn_n),
    .pulse_n(b_pulse_n), .pressed(b_pressed), .held(b_held)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s at step %0d: observed=%b expected=%b", tag, stepno, obs, exp);
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs == exp) n_pass++;
    else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_stable  = 1'b1;
    m_pressed = 1'b0;
    dq        = '{1'b1, 1'b1};
    hist.delete();
    for (int i = 0; i < 2; i++) begin
      m_pulse_n[i] = 1'b1;
      m_held[i]    = 1'b0;
      m_act[i]     = 1'b0;
      m_t[i]       = 0;
    end
  endtask

  // Outputs follow from the debounced level before the edge and time since the press.
  task automatic model_edge();
    logic s;
    bit   all_diff;
    if (!reset_n) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      bit rep_en;
      rep_en = (i == 0);
      if (!m_act[i]) begin
        m_held[i]    = 1'b0;
        m_pulse_n[i] = m_stable;
        if (!m_stable) begin
          m_act[i] = 1'b1;
          m_t[i]   = 0;
        end
      end else if (m_stable) begin
        m_act[i]     = 1'b0;
        m_pulse_n[i] = 1'b1;
        m_held[i]    = 1'b0;
      end else begin
        m_t[i]++;
        m_held[i]    = rep_en && (m_t[i] >= int'(RD));
        m_pulse_n[i] = !(m_held[i] && (((m_t[i] - int'(RD)) % int'(RP)) == 0));
      end
    end
    m_pressed = ~m_stable;
    s = dq[0];
    void'(dq.pop_front());
    dq.push_back(btn_n);
    hist.push_back(s);
    if (hist.size() > int'(DB)) void'(hist.pop_front());
    if (hist.size() == int'(DB)) begin
      all_diff = 1'b1;
      foreach (hist[j]) if (hist[j] == m_stable) all_diff = 1'b0;
      if (all_diff) m_stable = ~m_stable;
    end
  endtask

  task automatic step(input logic b, input logic rst);
    btn_n   = b;
    reset_n = rst;
    if (!rst) model_reset();
    @(posedge clk_ctrl);
    model_edge();
    #1;
    stepno++;
    chk("rep.pulse_n",   a_pulse_n, m_pulse_n[0]);
    chk("rep.pressed",   a_pressed, m_pressed);
    chk("rep.held",      a_held,    m_held[0]);
    chk("norep.pulse_n", b_pulse_n, m_pulse_n[1]);
    chk("norep.pressed", b_pressed, m_pressed);
    chk("norep.held",    b_held,    m_held[1]);
    if (a_pulse_n === 1'b0) a_strobes.push_back(stepno - t0);
    if (b_pulse_n === 1'b0) b_strobes.push_back(stepno - t0);
    if (a_held === 1'b1) a_held_seen = 1'b1;
    if (a_pressed === 1'b1) a_pressed_seen = 1'b1;
  endtask

  task automatic mark();
    t0 = stepno;
    a_strobes.delete();
    b_strobes.delete();
    a_held_seen    = 1'b0;
    a_pressed_seen = 1'b0;
  endtask

  initial begin
    logic lvl;
    int   len;
    btn_n   = 1'b1;
    reset_n = 1'b0;
    model_reset();
    mark();
    repeat (3) step(1'b1, 1'b0);
    repeat (5) step(1'b1, 1'b1);

    // Clean press held 8 cycles: single strobe 7 edges after the press.
    mark();
    repeat (8) step(1'b0, 1'b1);
    repeat (12) step(1'b1, 1'b1);
    chk_int("clean.strobe_count", a_strobes.size(), 1);
    if (a_strobes.size() > 0) chk_int("clean.strobe_edge", a_strobes[0], 7);
    chk_int("clean.held_seen", int'(a_held_seen), 0);

    // Bounce shorter than the debounce window is ignored.
    mark();
    repeat (3) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    repeat (2) step(1'b0, 1'b1);
    repeat (12) step(1'b1, 1'b1);
    chk_int("bounce.strobe_count", a_strobes.size(), 0);
    chk_int("bounce.pressed_seen", int'(a_pressed_seen), 0);

    // Long hold: press strobe, first repeat after RD, then every RP.
    mark();
    repeat (30) step(1'b0, 1'b1);
    repeat (15) step(1'b1, 1'b1);
    chk_int("hold.norep_count", b_strobes.size(), 1);
    if (a_strobes.size() >= 3) begin
      chk_int("hold.first", a_strobes[0], 7);
      chk_int("hold.repeat1", a_strobes[1], 17);
      chk_int("hold.repeat2", a_strobes[2], 20);
    end else begin
      chk_int("hold.rep_count_min", a_strobes.size(), 3);
    end
    chk_int("hold.held_seen", int'(a_held_seen), 1);
    chk("hold.held_after_release", a_held, 1'b0);

    // Reset mid-repeat with the button still held re-arms one press strobe.
    repeat (25) step(1'b0, 1'b1);
    repeat (2) step(1'b0, 1'b0);
    chk("rst.pulse_n", a_pulse_n, 1'b1);
    chk("rst.pressed", a_pressed, 1'b0);
    chk("rst.held",    a_held,    1'b0);
    mark();
    repeat (12) step(1'b0, 1'b1);
    chk_int("rst.strobe_count", a_strobes.size(), 1);
    if (a_strobes.size() > 0) chk_int("rst.strobe_edge", a_strobes[0], 7);
    repeat (12) step(1'b1, 1'b1);

    // Three clean presses toggle a downstream enable exactly three times.
    mark();
    repeat (3) begin
      repeat (9) step(1'b0, 1'b1);
      repeat (10) step(1'b1, 1'b1);
    end
    chk_int("toggle.count", b_strobes.size(), 3);

    // Randomised bouncing and holds against the model.
    lvl = 1'b1;
    repeat (60) begin
      lvl = ~lvl;
      len = (($urandom % 4) == 0) ? int'($urandom_range(10, 40)) : int'($urandom_range(1, 8));
      repeat (len) step(lvl, 1'b1);
      if (($urandom % 20) == 0) repeat (2) step(lvl, 1'b0);
    end
    repeat (20) step(1'b1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
